// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared encodings and instruction field positions for the decode stage
package decode_stage_pkg;
  localparam logic [1:0] IMM5 = 2'd0;
  localparam logic [1:0] IMM8 = 2'd1;
  localparam logic [1:0] IMM11 = 2'd2;
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RS = 2'd2;
  localparam logic [1:0] DST_R7 = 2'd3;
  localparam logic [2:0] R7 = 3'd7;
  localparam int RS_LSB = 8;
  localparam int RT_LSB = 5;
  localparam int RD_LSB = 2;
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 8-entry register file, two read ports with write-back bypass, one write port
module decode_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [2:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [2:0]        ra1,
  input  logic [2:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] regs [8];
  // write-back port; whole file clears on reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 8; i++) regs[i] <= '0;
    else if (we) regs[wa] <= wd;
  assign rd1 = (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (we && wa == ra2) ? wd : regs[ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: operand read, immediate extension, destination select and ID/EX register; RAW scoreboard when DECODE_SCOREBOARD_EN is defined
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [1:0]        imm_sel,
  input  logic              zero_ex,
  input  logic [1:0]        reg_dst,
  input  logic              reg_write,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_wr_reg,
  output logic              out_reg_write,
  output logic              err
);
  import decode_stage_pkg::*;
  logic [2:0] rs, rt, rd, dst;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic hazard, accept, unused_bits;
  assign rs = instr[RS_LSB +: 3];
  assign rt = instr[RT_LSB +: 3];
  assign rd = instr[RD_LSB +: 3];
  assign unused_bits = ^instr[15:11];
  decode_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk(clk), .rst(rst), .we(wb_en), .wa(wb_reg), .wd(wb_data),
    .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2)
  );
  assign imm = imm_sel == IMM5  ? {{(DATA_W-5){~zero_ex & instr[4]}}, instr[4:0]}
             : imm_sel == IMM8  ? {{(DATA_W-8){~zero_ex & instr[7]}}, instr[7:0]}
             : imm_sel == IMM11 ? {{(DATA_W-11){~zero_ex & instr[10]}}, instr[10:0]}
             : '0;
  assign dst = reg_dst == DST_RT ? rt : reg_dst == DST_RD ? rd : reg_dst == DST_RS ? rs : R7;
  assign in_ready = !flush && (!out_valid || out_ready) && !hazard;
  assign accept = in_valid && in_ready;
`ifdef DECODE_SCOREBOARD_EN
  logic [CNT_W-1:0] cnt [8];
  logic [CNT_W:0] tot [8];
  logic [CNT_W:0] dn [8];
  logic [7:0] busy, up, dwb, dfl;
  assign up = (accept && reg_write) ? 8'd1 << dst : 8'd0;
  assign dwb = wb_en ? 8'd1 << wb_reg : 8'd0;
  assign dfl = (flush && out_valid && out_reg_write) ? 8'd1 << out_wr_reg : 8'd0;
  // a register stays busy only if writers remain after this cycle's write-back retires one
  always_comb
    for (int r = 0; r < 8; r++) begin
      busy[r] = cnt[r] > CNT_W'(dwb[r]);
      tot[r] = {1'b0, cnt[r]} + (CNT_W+1)'(up[r]);
      dn[r] = (CNT_W+1)'(dwb[r]) + (CNT_W+1)'(dfl[r]);
    end
  assign hazard = (use_rs && busy[rs]) || (use_rt && busy[rt]) || (reg_write && &cnt[dst]);
  // in-flight writer counts, summed across sources and floored at zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int r = 0; r < 8; r++) cnt[r] <= '0;
    else for (int r = 0; r < 8; r++) cnt[r] <= tot[r] > dn[r] ? CNT_W'(tot[r] - dn[r]) : '0;
`else
  logic unused_sb;
  assign hazard = 1'b0;
  assign unused_sb = use_rs | use_rt | (CNT_W == 0);
`endif
  // ID/EX register: load on accept, drop on consume or flush
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      out_rd1 <= '0;
      out_rd2 <= '0;
      out_imm <= '0;
      out_wr_reg <= '0;
      out_reg_write <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_rd1 <= rd1;
      out_rd2 <= rd2;
      out_imm <= imm;
      out_wr_reg <= dst;
      out_reg_write <= reg_write;
      err <= &imm_sel;
    end else if (flush || out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a behavioural model
module tb_decode_stage;
  logic clk = 0, rst = 0;
  logic in_valid, in_ready, zero_ex, reg_write, use_rs, use_rt, flush, wb_en;
  logic out_valid, out_ready, out_reg_write, err;
  logic [15:0] instr, wb_data, out_rd1, out_rd2, out_imm;
  logic [1:0] imm_sel, reg_dst;
  logic [2:0] wb_reg, out_wr_reg;
  int passed = 0, total = 0;
  logic [15:0] mregs [8];
  logic m_valid, m_rw, m_err;
  logic [15:0] m_rd1, m_rd2, m_imm;
  logic [2:0] m_wr;
  int q[$];

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .imm_sel(imm_sel), .zero_ex(zero_ex), .reg_dst(reg_dst), .reg_write(reg_write),
    .use_rs(use_rs), .use_rt(use_rt), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_rd1(out_rd1),
    .out_rd2(out_rd2), .out_imm(out_imm), .out_wr_reg(out_wr_reg),
    .out_reg_write(out_reg_write), .err(err)
  );

  function automatic logic [15:0] ext_imm(logic [15:0] i, logic [1:0] sel, logic zx);
    int w, v;
    if (sel == 2'd3) return 16'h0;
    w = sel == 2'd0 ? 5 : sel == 2'd1 ? 8 : 11;
    v = int'(i) % (1 << w);
    if (!zx && v >= (1 << (w - 1))) v = v - (1 << w);
    return 16'(v);
  endfunction

  function automatic logic [2:0] dst_of(logic [15:0] i, logic [1:0] rd);
    int v = int'(i);
    case (rd)
      2'd0: return 3'((v >> 5) % 8);
      2'd1: return 3'((v >> 2) % 8);
      2'd2: return 3'((v >> 8) % 8);
      default: return 3'd7;
    endcase
  endfunction

  function automatic int inflight(int r);
    int n = 0;
    foreach (q[i]) if (q[i] == r) n++;
    return n;
  endfunction

  function automatic void q_remove(int r);
    for (int i = 0; i < q.size(); i++) if (q[i] == r) begin q.delete(i); return; end
  endfunction

  function automatic bit m_hazard();
`ifdef DECODE_SCOREBOARD_EN
    int rs = (int'(instr) >> 8) % 8;
    int rt = (int'(instr) >> 5) % 8;
    int wbr = wb_en ? int'(wb_reg) : -1;
    int d = int'(dst_of(instr, reg_dst));
    return (use_rs && inflight(rs) - int'(wbr == rs) > 0) ||
           (use_rt && inflight(rt) - int'(wbr == rt) > 0) ||
           (reg_write && inflight(d) >= 3);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void m_reset();
    foreach (mregs[i]) mregs[i] = 16'h0;
    m_valid = 0; m_rw = 0; m_err = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_wr = 0;
    q.delete();
  endfunction

  task automatic idle();
    in_valid = 0; instr = 0; imm_sel = 0; zero_ex = 0; reg_dst = 0; reg_write = 0;
    use_rs = 0; use_rt = 0; flush = 0; wb_en = 0; wb_reg = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic issue(logic [15:0] i, logic [1:0] sel, logic zx, logic [1:0] rdst, logic rw, logic urs, logic urt);
    in_valid = 1; instr = i; imm_sel = sel; zero_ex = zx; reg_dst = rdst; reg_write = rw;
    use_rs = urs; use_rt = urt;
  endtask

  task automatic cyc(string nm);
    bit exp_ready, acc;
    logic [15:0] v1, v2;
    #1;
    exp_ready = !flush && (!m_valid || out_ready) && !m_hazard();
    total++;
    if (in_ready !== exp_ready) $display("FAIL %s in_ready got %b want %b", nm, in_ready, exp_ready);
    else passed++;
    acc = in_valid && exp_ready;
    v1 = (wb_en && wb_reg == instr[10:8]) ? wb_data : mregs[instr[10:8]];
    v2 = (wb_en && wb_reg == instr[7:5]) ? wb_data : mregs[instr[7:5]];
    if (acc) begin
      m_valid = 1; m_rd1 = v1; m_rd2 = v2; m_imm = ext_imm(instr, imm_sel, zero_ex);
      m_wr = dst_of(instr, reg_dst); m_rw = reg_write; m_err = imm_sel == 2'd3;
      if (reg_write) q.push_back(int'(m_wr));
    end else if (flush || out_ready) begin
      if (flush && m_valid && m_rw) q_remove(int'(m_wr));
      m_valid = 0;
    end
    if (wb_en) begin
      mregs[wb_reg] = wb_data;
      q_remove(int'(wb_reg));
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== m_valid) $display("FAIL %s out_valid got %b want %b", nm, out_valid, m_valid);
    else passed++;
    total++;
    if ({out_rd1, out_rd2, out_imm, out_wr_reg, out_reg_write, err} !== {m_rd1, m_rd2, m_imm, m_wr, m_rw, m_err})
      $display("FAIL %s outputs got rd1=%h rd2=%h imm=%h wr=%0d rw=%b err=%b want rd1=%h rd2=%h imm=%h wr=%0d rw=%b err=%b",
               nm, out_rd1, out_rd2, out_imm, out_wr_reg, out_reg_write, err,
               m_rd1, m_rd2, m_imm, m_wr, m_rw, m_err);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 0; idle(); m_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_rd1, out_rd2, out_imm, out_wr_reg, out_reg_write, err} !== 54'h0)
      $display("FAIL reset outputs got valid=%b imm=%h err=%b want all zero", out_valid, out_imm, err);
    else passed++;
    rst = 1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_imm();
    idle(); issue(16'h4A1F, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); cyc("imm5");
    total++;
    if (out_imm !== 16'hFFFF || out_valid !== 1'b1 || err !== 1'b0)
      $display("FAIL imm5 got imm=%h valid=%b err=%b want FFFF 1 0", out_imm, out_valid, err);
    else passed++;
    issue(16'h4A1F, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0); cyc("imm8z");
    issue(16'hC5A5, 2'd2, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0); cyc("imm11s");
    issue(16'h4A1F, 2'd3, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0); cyc("imm_bad");
    total++;
    if (err !== 1'b1 || out_imm !== 16'h0) $display("FAIL imm_bad got err=%b imm=%h want 1 0000", err, out_imm);
    else passed++;
    idle(); cyc("imm_drain");
  endtask

  task automatic test_bypass();
    idle(); issue(16'h0300, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    wb_en = 1; wb_reg = 3'd3; wb_data = 16'h1234;
    cyc("bypass");
    total++;
    if (out_rd1 !== 16'h1234) $display("FAIL bypass rd1 got %h want 1234", out_rd1);
    else passed++;
    idle(); cyc("bypass_idle");
  endtask

  task automatic test_stall();
    idle(); issue(16'h0123, 2'd1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0); cyc("stall_first");
    out_ready = 0; issue(16'h0777, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) $display("FAIL stall in_ready got %b want 0", in_ready);
      else passed++;
      cyc("stall_hold");
    end
    out_ready = 1; cyc("stall_release");
    total++;
    if (out_imm !== 16'h0077) $display("FAIL stall_release imm got %h want 0077", out_imm);
    else passed++;
    idle(); cyc("stall_drain");
  endtask

  task automatic test_flush();
    idle(); out_ready = 0; issue(16'h0500, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0); cyc("flush_writer");
    idle(); out_ready = 0; flush = 1; cyc("flush_kill");
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_kill out_valid got %b want 0", out_valid);
    else passed++;
    idle(); issue(16'h0500, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL flush_reader in_ready got %b want 1", in_ready);
    else passed++;
    cyc("flush_reader");
    idle(); flush = 1; cyc("flush_empty");
    idle(); cyc("flush_drain");
  endtask

`ifdef DECODE_SCOREBOARD_EN
  task automatic test_scoreboard();
    idle(); issue(16'h0040, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); cyc("sb_writer");
    issue(16'h0200, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) $display("FAIL sb_stall in_ready got %b want 0", in_ready);
      else passed++;
      cyc("sb_stall");
    end
    wb_en = 1; wb_reg = 3'd2; wb_data = 16'hABCD; cyc("sb_wb");
    total++;
    if (out_valid !== 1'b1 || out_rd1 !== 16'hABCD)
      $display("FAIL sb_wb got valid=%b rd1=%h want 1 ABCD", out_valid, out_rd1);
    else passed++;
    idle(); cyc("sb_drain");
  endtask
`else
  task automatic test_back_to_back();
    idle(); issue(16'h0040, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); cyc("b2b_writer");
    issue(16'h0200, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL b2b in_ready got %b want 1", in_ready);
    else passed++;
    cyc("b2b_reader");
    idle(); cyc("b2b_drain");
  endtask
`endif

  task automatic test_random(int n);
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom % 4) != 0; instr = 16'($urandom); imm_sel = 2'($urandom);
      zero_ex = 1'($urandom); reg_dst = 2'($urandom); reg_write = 1'($urandom);
      use_rs = 1'($urandom); use_rt = 1'($urandom); flush = ($urandom % 10) == 0;
      out_ready = ($urandom % 4) != 0; wb_en = ($urandom % 3) == 0;
      wb_reg = 3'($urandom); wb_data = 16'($urandom);
      cyc("random");
    end
  endtask

  task automatic test_reset_mid();
    test_random(20);
    #2 rst = 0;
    #1;
    total++;
    if (out_valid !== 1'b0 || err !== 1'b0 || out_imm !== 16'h0)
      $display("FAIL reset_mid got valid=%b err=%b imm=%h want 0 0 0000", out_valid, err, out_imm);
    else passed++;
    idle(); m_reset();
    @(posedge clk);
    #1 rst = 1;
    wb_en = 1; wb_reg = 3'd1; wb_data = 16'hBEEF; cyc("reset_wb");
    idle(); issue(16'h0100, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0); cyc("reset_read");
    total++;
    if (out_rd1 !== 16'hBEEF) $display("FAIL reset_read rd1 got %h want BEEF", out_rd1);
    else passed++;
    idle(); cyc("reset_drain");
  endtask

  initial begin
    test_reset();
    test_imm();
    test_bypass();
    test_stall();
    test_flush();
`ifdef DECODE_SCOREBOARD_EN
    test_scoreboard();
`else
    test_back_to_back();
`endif
    test_random(400);
    test_reset_mid();
    test_random(200);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined successor to the single-cycle decode block. It holds the 8-entry register file with write-back bypass, extends immediates to the datapath width, and selects the destination register. Results are registered into an ID/EX output stage with a valid/ready handshake. An optional per-register scoreboard stalls the fetch side on RAW hazards. It sits between fetch (upstream handshake) and execute (downstream handshake), and receives write-back directly.

## Interface
- DATA_W, 16, register/immediate/write-back width (16..64)
- CNT_W, 2, scoreboard in-flight counter width per register
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- instr  in  16  instruction; rs=[10:8], rt=[7:5], R-rd=[4:2]
- imm_sel  in  2  0: imm5 [4:0], 1: imm8 [7:0], 2: imm11 [10:0], 3: illegal
- zero_ex  in  1  1 zero-extend, 0 sign-extend
- reg_dst  in  2  0: [7:5], 1: [4:2], 2: [10:8], 3: R7
- reg_write  in  1  instruction writes a register
- use_rs, use_rt  in  1 each  instruction reads rs / rt
- flush  in  1  kill the held output instruction
- wb_en  in  1  write-back strobe
- wb_reg  in  3  write-back register
- wb_data  in  DATA_W  write-back data
- out_valid  out  1  output stage holds an instruction
- out_ready  in  1  execute accepts
- out_rd1, out_rd2  out  DATA_W  rs / rt operand values
- out_imm  out  DATA_W  extended immediate
- out_wr_reg  out  3  destination register
- out_reg_write  out  1  destination write enable
- err  out  1  registered; illegal imm_sel captured

## Operation
- Accept is in_valid && in_ready. On accept, all out_* and err load from the current decode. The output holds until out_valid && out_ready, or until flush.
- in_ready = !flush && (!out_valid || out_ready) && !hazard.
- Register file: 8 x DATA_W, reset to 0. Written on wb_en. Reads bypass: if wb_en and wb_reg equals the read index, the read returns wb_data.
- Immediate: the field is sign- or zero-extended to DATA_W. For imm_sel=3, out_imm=0 and err=1.
- Scoreboard: cnt[r] counts in-flight writers of register r.
  - Increment on accept with reg_write, for out_wr_reg.
  - Decrement on wb_en, for wb_reg.
  - Decrement when flush kills a valid output with out_reg_write, for its out_wr_reg.
  - Increment and decrement on the same register in the same cycle cancel. All sources are summed.
- hazard = (use_rs && eff_cnt[rs]!=0) || (use_rt && eff_cnt[rt]!=0) || (reg_write && cnt[dst] at maximum).
  - eff_cnt is cnt minus this cycle's write-back, so a same-cycle write-back clears the hazard and the bypass supplies the data.
- Flush: clears out_valid next edge and blocks accept that cycle. Flush with out_valid=0 is a no-op.
- Reset mid-operation: all state clears asynchronously, including in-flight counts. A write-back arriving after reset is ignored by the scoreboard because the count saturates at 0, but it still writes the register file.

## Timing
- One-cycle latency: an instruction accepted at edge N appears on out_* after edge N.
- Full throughput when out_ready=1 and there are no hazards.
- Reset values: out_valid=0, out_rd1=out_rd2=out_imm=0, out_wr_reg=0, out_reg_write=0, err=0, all cnt=0. in_ready=1 after reset, because out_valid=0 and cnt=0.
- in_ready depends combinationally on out_ready, flush, wb_en and wb_reg. There is no combinational path from in_valid to in_ready.

## Configuration
- DECODE_SCOREBOARD_EN defined: scoreboard and hazard logic are present as described.
- DECODE_SCOREBOARD_EN undefined:
  - hazard is constant 0 and no counters exist.
  - use_rs and use_rt are ignored.
  - in_ready = !flush && (!out_valid || out_ready).

## Structure
- Shared package holds:
  - imm_sel encodings (IMM5, IMM8, IMM11), reg_dst encodings, and R7 index constant.
  - Instruction field position constants.
- One sub-module, decode_regfile: 8 x DATA_W, two read ports, one write port, read bypass, asynchronous active-low reset.
- Immediate extension, destination mux, scoreboard and output register live in decode_stage.

## Test plan
- Reset, then accept instr 16'h4A1F with imm_sel=0, zero_ex=0 -> out_imm=16'hFFFF, out_valid=1 one cycle later, err=0.
- Write-back R3=16'h1234 in the same cycle as accepting an instruction with rs=R3 -> out_rd1=16'h1234.
- Scoreboard enabled: accept a writer of R2, then present a reader of R2 -> in_ready=0 until wb_en with wb_reg=2. Accept occurs in the wb cycle with out_rd1=wb_data.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no instruction lost or duplicated.
- Flush a valid writer of R5 -> out_valid=0 next cycle, cnt[5] back to 0, and a following R5 reader is accepted immediately.
- imm_sel=3 -> err=1, out_imm=0. Scoreboard disabled: back-to-back R-after-W instructions accepted every cycle.
